// File: rtl/button_event_arbiter_pkg.sv
// Shared definitions for the button event arbiter.
//   ST_A / ST_B   : press/release detector state codes (released / pressed)
//   N_DEFAULT     : default number of button channels
//   clog2()       : ceiling log2, used to size and check the channel index width
package btn_defs;

   typedef enum logic {
      ST_A = 1'b0,
      ST_B = 1'b1
   } btn_state_t;

   localparam int N_DEFAULT = 4;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int k = 0; k < 31; k++) begin
         if ((1 << k) < v) r = k + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/button_event_arbiter_if.sv
// Event output slot handshake between the arbiter and the event consumer.
//   ev_valid : slot holds an event          (arbiter -> consumer)
//   ev_id    : channel index of that event  (arbiter -> consumer)
//   ev_ready : consumer accepts the event   (consumer -> arbiter)
// A transfer happens on a clock edge where ev_valid & ev_ready.
interface button_event_arbiter_if
   import btn_defs::*;
#(
   parameter int IDW = clog2(N_DEFAULT)
);
   logic           ev_valid;
   logic [IDW-1:0] ev_id;
   logic           ev_ready;

   modport master (output ev_valid, output ev_id, input ev_ready);
   modport slave  (input ev_valid, input ev_id, output ev_ready);
endinterface

// File: rtl/button_event_arbiter_cell.sv
// One press/release detector.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, returns the detector to ST_A
//   y   : button level, already synchronous to clk
//   e   : release event, high for the cycle where the button was pressed at the
//         last edge and is now low (Mealy output, combinational from y)
module button_event_cell
   import btn_defs::*;
(
   input  logic clk,
   input  logic rst,
   input  logic y,
   output logic e
);

   btn_state_t ps;

   always_ff @(posedge clk) begin
      if (rst) ps <= ST_A;
      else     ps <= y ? ST_B : ST_A;
   end

   assign e = (ps == ST_B) && !y;

endmodule

// File: rtl/button_event_arbiter.sv
// Shares one event consumer between N push-buttons.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, clears all state
//   y        : N button levels, synchronous to clk
//   ev       : event slot handshake (master side: ev_valid, ev_id out; ev_ready in)
//   pend     : per-channel pending flags (queued, not yet moved into the slot)
//   drop_cnt : saturating count of events lost because their channel was full
// Each channel holds at most two events: one in pend, one in the output slot.
// The slot is refilled round-robin from registered pend, starting at ptr.
module button_event_arbiter
   import btn_defs::*;
#(
   parameter int N   = N_DEFAULT,
   parameter int IDW = 2
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N-1:0]                  y,
   button_event_arbiter_if.master        ev,
   output logic [N-1:0]                  pend,
   output logic [7:0]                    drop_cnt
);

   if (N < 2 || N > 16) begin : g_bad_n
      $error("button_event_arbiter: N must be in 2..16");
   end
   if (IDW != clog2(N)) begin : g_bad_idw
      $error("button_event_arbiter: IDW must equal clog2(N)");
   end

   logic [N-1:0]   evt;
   logic           slot_valid;
   logic [IDW-1:0] slot_id;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] win;
   logic [IDW-1:0] ptr_nxt;
   logic           load;
   logic [N-1:0]   clr;
   logic [N-1:0]   pend_nxt;
   logic [N-1:0]   drop_vec;
   logic [8:0]     drop_sum;

   for (genvar g = 0; g < N; g++) begin : g_cell
      button_event_cell u_cell (
         .clk (clk),
         .rst (rst),
         .y   (y[g]),
         .e   (evt[g])
      );
   end

   // First requesting channel scanning start, start+1, ... modulo N.
   function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] req,
                                              input logic [IDW-1:0] start);
      logic [IDW-1:0] pick;
      logic           found;
      int             idx;
      pick  = start;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(start) + k) % N;
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = IDW'(idx);
         end
      end
      return pick;
   endfunction

   function automatic logic [7:0] sat8(input logic [8:0] v);
      return (v > 9'd255) ? 8'hFF : v[7:0];
   endfunction

   always_comb begin
      clr      = '0;
      pend_nxt = '0;
      drop_vec = '0;
      load     = (!slot_valid || ev.ev_ready) && (|pend);
      win      = rr_pick(pend, ptr);
      ptr_nxt  = (int'(win) == N - 1) ? '0 : win + IDW'(1);
      for (int i = 0; i < N; i++) begin
         clr[i]      = load && (win == IDW'(i));
         // A new event on the channel being granted this edge refills pend.
         pend_nxt[i] = (pend[i] && !clr[i]) || evt[i];
         drop_vec[i] = evt[i] && pend[i] && !clr[i];
      end
      drop_sum = {1'b0, drop_cnt};
      for (int i = 0; i < N; i++) begin
         drop_sum = drop_sum + 9'(drop_vec[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend       <= '0;
         slot_valid <= 1'b0;
         slot_id    <= '0;
         ptr        <= '0;
         drop_cnt   <= '0;
      end else begin
         pend     <= pend_nxt;
         drop_cnt <= sat8(drop_sum);
         if (load) begin
            slot_valid <= 1'b1;
            slot_id    <= win;
            ptr        <= ptr_nxt;
         end else if (slot_valid && ev.ev_ready) begin
            // Transfer with nothing pending: empty the slot, keep the last id.
            slot_valid <= 1'b0;
         end
      end
   end

   assign ev.ev_valid = slot_valid;
   assign ev.ev_id    = slot_id;

endmodule
